// File: rtl/alu_sequencer.sv
// Sequences one ALU operation through latch-based operand/result registers:
// load A, load B, let the ALU settle, strobe the result, pulse done.
module alu_sequencer #(
  parameter int BIT_COUNT   = 8,
  parameter int OP_BITS     = 3,
  parameter int EXEC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BIT_COUNT-1:0] op_a,
  input  logic [BIT_COUNT-1:0] op_b,
  input  logic [OP_BITS-1:0]   opcode,
  output logic                 ready,
  output logic                 busy,
  output logic [BIT_COUNT-1:0] bus_data,
  output logic                 store_a,
  output logic                 store_b,
  output logic                 store_result,
  output logic [OP_BITS-1:0]   alu_opcode,
  output logic                 done
);

  localparam int EXEC_EFF = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int CNT_W    = (EXEC_EFF > 1) ? $clog2(EXEC_EFF) : 1;
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_HOLD_A,
    S_LOAD_B,
    S_HOLD_B,
    S_EXECUTE,
    S_WRITE_BACK,
    S_DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     exec_cnt;
  logic [BIT_COUNT-1:0] b_hold;

  // NOTE: b_hold is pure data that is always written at accept before it is
  // ever driven onto the bus, so it carries no reset and stays a plain flop.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      b_hold <= op_b;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all flops update
  // together from pre-edge values; blocking would create order-dependent logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ready        <= 1'b1;
      busy         <= 1'b0;
      store_a      <= 1'b0;
      store_b      <= 1'b0;
      store_result <= 1'b0;
      done         <= 1'b0;
      bus_data     <= '0;
      alu_opcode   <= '0;
      exec_cnt     <= '0;
    end else begin
      // Strobes default low so each one is exactly a single cycle wide.
      store_a      <= 1'b0;
      store_b      <= 1'b0;
      store_result <= 1'b0;
      done         <= 1'b0;

      if (state != S_IDLE && abort) begin
        state    <= S_IDLE;
        ready    <= 1'b1;
        busy     <= 1'b0;
        exec_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_LOAD_A;
              store_a    <= 1'b1;
              bus_data   <= op_a;
              alu_opcode <= opcode;
              ready      <= 1'b0;
              busy       <= 1'b1;
            end
          end
          S_LOAD_A: state <= S_HOLD_A;
          S_HOLD_A: begin
            state    <= S_LOAD_B;
            store_b  <= 1'b1;
            bus_data <= b_hold;
          end
          S_LOAD_B: state <= S_HOLD_B;
          S_HOLD_B: begin
            state    <= S_EXECUTE;
            exec_cnt <= '0;
          end
          S_EXECUTE: begin
            if (exec_cnt == EXEC_LAST) begin
              state        <= S_WRITE_BACK;
              store_result <= 1'b1;
              exec_cnt     <= '0;
            end else begin
              exec_cnt <= exec_cnt + 1'b1;
            end
          end
          S_WRITE_BACK: begin
            state <= S_DONE;
            done  <= 1'b1;
          end
          S_DONE: begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: three builds (EXEC_CYCLES 2, 1, 0) share stimulus and
// are compared every cycle against a phase-timeline model of the operation.
module tb_alu_sequencer;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [2:0] opcode;

  logic       ready_w [N];
  logic       busy_w  [N];
  logic       sa_w    [N];
  logic       sb_w    [N];
  logic       sr_w    [N];
  logic       done_w  [N];
  logic [7:0] bus_w   [N];
  logic [2:0] opc_w   [N];

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.BIT_COUNT(8), .OP_BITS(3), .EXEC_CYCLES(2)) u_e2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .ready(ready_w[0]), .busy(busy_w[0]), .bus_data(bus_w[0]),
    .store_a(sa_w[0]), .store_b(sb_w[0]), .store_result(sr_w[0]),
    .alu_opcode(opc_w[0]), .done(done_w[0])
  );

  alu_sequencer #(.BIT_COUNT(8), .OP_BITS(3), .EXEC_CYCLES(1)) u_e1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .ready(ready_w[1]), .busy(busy_w[1]), .bus_data(bus_w[1]),
    .store_a(sa_w[1]), .store_b(sb_w[1]), .store_result(sr_w[1]),
    .alu_opcode(opc_w[1]), .done(done_w[1])
  );

  alu_sequencer #(.BIT_COUNT(8), .OP_BITS(3), .EXEC_CYCLES(0)) u_e0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .ready(ready_w[2]), .busy(busy_w[2]), .bus_data(bus_w[2]),
    .store_a(sa_w[2]), .store_b(sb_w[2]), .store_result(sr_w[2]),
    .alu_opcode(opc_w[2]), .done(done_w[2])
  );

  // Effective settle cycles of each build (0 behaves as 1).
  function automatic int eff(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s[%0d] actual=%0h expected=%0h time=%0t", name, idx, act, exp, $time);
    end
  endtask

  // Model: ph = cycle index within the current operation (0 = idle).
  // Cycle 1 loads A, 3 loads B, 5+E writes back, 6+E is done.
  int         ph    [N];
  logic [7:0] m_bus [N];
  logic [7:0] m_b   [N];
  logic [2:0] m_opc [N];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        ph[i]    <= 0;
        m_bus[i] <= 8'h00;
        m_opc[i] <= 3'd0;
      end else if (ph[i] == 0) begin
        if (start) begin
          ph[i]    <= 1;
          m_bus[i] <= op_a;
          m_b[i]   <= op_b;
          m_opc[i] <= opcode;
        end
      end else if (abort || ph[i] == 6 + eff(i)) begin
        ph[i] <= 0;
      end else begin
        ph[i] <= ph[i] + 1;
        if (ph[i] == 2) m_bus[i] <= m_b[i];
      end
    end
  end

  int done_cnt = 0;
  int sr_cnt   = 0;
  int sa_cnt   = 0;
  int sa_prev  = 0;
  int sa_last  = 0;
  int ncyc     = 0;
  bit saw_ff   = 1'b0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (run && !reset) begin
      for (int i = 0; i < N; i++) begin
        check("ready",        i, ready_w[i], ph[i] == 0);
        check("busy",         i, busy_w[i],  ph[i] != 0);
        check("store_a",      i, sa_w[i],    ph[i] == 1);
        check("store_b",      i, sb_w[i],    ph[i] == 3);
        check("store_result", i, sr_w[i],    ph[i] == 5 + eff(i));
        check("done",         i, done_w[i],  ph[i] == 6 + eff(i));
        check("bus_data",     i, bus_w[i],   m_bus[i]);
        check("alu_opcode",   i, opc_w[i],   m_opc[i]);
        check("store_onehot", i, $countones({sa_w[i], sb_w[i], sr_w[i]}) <= 1, 1);
      end
      if (done_w[0]) done_cnt = done_cnt + 1;
      if (sr_w[0])   sr_cnt   = sr_cnt + 1;
      if (sa_w[0]) begin
        sa_cnt  = sa_cnt + 1;
        sa_prev = sa_last;
        sa_last = ncyc;
      end
      if (bus_w[0] == 8'hFF) saw_ff = 1'b1;
    end
  end

  int d0;
  int r0;
  int s0;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    op_a = 8'h00; op_b = 8'h00; opcode = 3'd0;
    #1 reset = 1'b1;
    #2;
    for (int i = 0; i < N; i++) begin
      check("rst_ready", i, ready_w[i], 1);
      check("rst_busy",  i, busy_w[i],  0);
      check("rst_strobes", i, {sa_w[i], sb_w[i], sr_w[i], done_w[i]}, 0);
      check("rst_bus",   i, bus_w[i],   0);
      check("rst_opc",   i, opc_w[i],   0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;

    // Basic operation with literal timeline expectations.
    op_a = 8'h3C; op_b = 8'hA5; opcode = 3'b010; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; op_a = 8'h5A; op_b = 8'h00; opcode = 3'b111;
      end
      case (c)
        1: begin
          check("t1_store_a", 0, sa_w[0], 1);
          check("t1_bus_a",   0, bus_w[0], 8'h3C);
          check("t1_opc",     0, opc_w[0], 2);
        end
        3: begin
          check("t1_store_b", 0, sb_w[0], 1);
          check("t1_bus_b",   0, bus_w[0], 8'hA5);
        end
        7: begin
          check("t1_store_result", 0, sr_w[0], 1);
          check("t1_done_exec1",   1, done_w[1], 1);
          check("t1_done_exec0",   2, done_w[2], 1);
          check("t1_bus_held",     0, bus_w[0], 8'hA5);
        end
        8: begin
          check("t1_done",       0, done_w[0], 1);
          check("t1_model_done", 0, ph[0] == 8, 1);
          check("t1_not_ready",  0, ready_w[0], 0);
        end
        9: begin
          check("t1_ready",   0, ready_w[0], 1);
          check("t1_opc_hold", 0, opc_w[0], 2);
        end
        default: ;
      endcase
    end

    // Start while busy is ignored.
    d0 = done_cnt; saw_ff = 1'b0;
    op_a = 8'h11; op_b = 8'h22; opcode = 3'b001; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = (c == 4);
      op_a  = (c == 4) ? 8'hFF : 8'h11;
    end
    start = 1'b0;
    check("t2_done_count", 0, done_cnt - d0, 1);
    check("t2_no_ff_bus",  0, saw_ff, 0);

    // Back-to-back: start held high accepts again in the first idle cycle.
    s0 = sa_cnt; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      op_a = 8'($urandom); op_b = 8'($urandom); opcode = 3'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("t3_ops",     0, sa_cnt - s0, 2);
    check("t3_spacing", 0, sa_last - sa_prev, 9);

    // Abort during EXECUTE.
    d0 = done_cnt; r0 = sr_cnt;
    op_a = 8'h3C; op_b = 8'hA5; opcode = 3'b010; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      abort = (c == 5);
      if (c == 6) begin
        check("t4_ready", 0, ready_w[0], 1);
        check("t4_bus",   0, bus_w[0], 8'hA5);
      end
    end
    abort = 1'b0;
    check("t4_no_done",   0, done_cnt - d0, 0);
    check("t4_no_result", 0, sr_cnt - r0, 0);

    // Asynchronous reset in HOLD_B acts before the next edge.
    op_a = 8'h77; op_b = 8'h66; opcode = 3'd5; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check("t5_ready",   i, ready_w[i], 1);
      check("t5_busy",    i, busy_w[i], 0);
      check("t5_strobes", i, {sa_w[i], sb_w[i], sr_w[i], done_w[i]}, 0);
      check("t5_bus",     i, bus_w[i], 0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op_a = 8'h01; op_b = 8'h02; opcode = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_store_a", 0, sa_w[0], 1);
    check("t5_bus_a",   0, bus_w[0], 8'h01);
    repeat (12) @(negedge clk);

    // Randomized traffic with occasional aborts and mid-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      abort  = ($urandom_range(0, 24) == 0);
      op_a   = 8'($urandom);
      op_b   = 8'($urandom);
      opcode = 3'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #3 reset = 1'b1;
        #4 reset = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
